// File: rtl/braid_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : braid_pulse_scheduler
// Desc     : Arbitrates N_REQ requesters for the Sigma-X braid pulse generator.
//            It drives each granted pulse for exactly its requested width and
//            then holds a guard interval. A width below MIN_TICKS or an external
//            fault latches a sticky SCRAM until it is cleared.
//            Define ALETHEIA_SCHED_RR_EN for round-robin arbitration. When the
//            macro is undefined, arbitration is fixed priority (lowest index).
// Revision : 1.0  initial release
// ============================================================================
module braid_pulse_scheduler #(
    parameter int N_REQ       = 4,
    parameter int MIN_TICKS   = 10,
    parameter int GUARD_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_width,
    input  logic                 scram_ext,
    input  logic                 scram_clear,
    output logic [N_REQ-1:0]     grant,
    output logic                 pulse_out,
    output logic [2:0]           pulse_owner,
    output logic                 busy,
    output logic                 safety_scram,
    output logic [3:0]           scram_src
);

    localparam logic [8:0] c_MIN_TICKS  = 9'(MIN_TICKS);
    localparam logic [7:0] c_GUARD_LOAD = (GUARD_TICKS > 0) ? 8'(GUARD_TICKS - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GUARD = 2'd2,
        S_SCRAM = 2'd3
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic               r_pulse;
    logic [2:0]         r_owner;
    logic               r_busy;
    logic               r_scram;
    logic [3:0]         r_src;

    logic [2:0]         w_winner;
    logic [7:0]         w_width;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_violation;
    logic               w_arb;
    logic               w_fire_grant;
    logic               w_fire_viol;
    logic               w_clear;

`ifdef ALETHEIA_SCHED_RR_EN
    logic [2:0]         r_ptr;
    logic               w_found;

    // Search starts at the pointer and wraps modulo N_REQ.
    always_comb begin
        w_winner = 3'd0;
        w_found  = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && req[i] && (((int'(r_ptr) + off) % N_REQ) == i)) begin
                    w_found  = 1'b1;
                    w_winner = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd0;
        end else if (w_clear) begin
            r_ptr <= 3'd0;
        end else if (w_fire_grant) begin
            r_ptr <= 3'((int'(w_winner) + 1) % N_REQ);
        end
    end
`else
    always_comb begin
        w_winner = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_winner = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        w_width = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_width = req_width[8*i +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_winner == 3'(gi));
        end
    endgenerate

    // The final guard cycle doubles as an arbitration slot, so held requests
    // see back-to-back grants spaced exactly width + guard cycles apart.
    assign w_arb        = (|req) && ((r_state == S_IDLE) ||
                                     ((r_state == S_GUARD) && (r_cnt == 8'd0)));
    assign w_violation  = ({1'b0, w_width} < c_MIN_TICKS);
    assign w_fire_grant = !scram_ext && w_arb && !w_violation;
    assign w_fire_viol  = !scram_ext && w_arb && w_violation;
    assign w_clear      = (r_state == S_SCRAM) && scram_clear && !scram_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_grant <= '0;
            r_pulse <= 1'b0;
            r_owner <= 3'd0;
            r_busy  <= 1'b0;
            r_scram <= 1'b0;
            r_src   <= 4'd0;
        end else begin
            r_grant <= '0;
            if ((r_state != S_SCRAM) && scram_ext) begin
                r_state <= S_SCRAM;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
                r_scram <= 1'b1;
                r_src   <= {1'b1, r_owner};
            end else if (w_fire_viol) begin
                r_state <= S_SCRAM;
                r_busy  <= 1'b0;
                r_scram <= 1'b1;
                r_src   <= {1'b0, w_winner};
            end else if (w_fire_grant) begin
                r_state <= S_PULSE;
                r_grant <= w_onehot;
                r_pulse <= 1'b1;
                r_owner <= w_winner;
                r_busy  <= 1'b1;
                r_cnt   <= w_width - 8'd1;
            end else begin
                case (r_state)
                    S_PULSE: begin
                        if (r_cnt == 8'd0) begin
                            r_pulse <= 1'b0;
                            if (GUARD_TICKS == 0) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_GUARD;
                                r_cnt   <= c_GUARD_LOAD;
                            end
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    S_GUARD: begin
                        if (r_cnt == 8'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    S_SCRAM: begin
                        if (w_clear) begin
                            r_state <= S_IDLE;
                            r_scram <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign grant        = r_grant;
    assign pulse_out    = r_pulse;
    assign pulse_owner  = r_owner;
    assign busy         = r_busy;
    assign safety_scram = r_scram;
    assign scram_src    = r_src;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_grant));
    a_pulse_busy:   assert property (@(posedge clk) disable iff (!rst_n) r_pulse |-> r_busy);
    a_scram_quiet:  assert property (@(posedge clk) disable iff (!rst_n) r_scram |-> !r_pulse);

endmodule

`default_nettype wire

// File: tb/tb_braid_pulse_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_braid_pulse_scheduler
// Desc     : Two schedulers (guard 4 and guard 0) share one stimulus stream and
//            are compared each cycle against a timestamp-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_braid_pulse_scheduler;

    localparam int N     = 4;
    localparam int MIN_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_width;
    logic             scram_ext;
    logic             scram_clear;

    logic [N-1:0]     grant_o [2];
    logic             pulse_o [2];
    logic [2:0]       owner_o [2];
    logic             busy_o  [2];
    logic             scram_o [2];
    logic [3:0]       src_o   [2];

    int gt [2] = '{4, 0};

    always #5 clk = ~clk;

    braid_pulse_scheduler #(.N_REQ(N), .MIN_TICKS(MIN_W), .GUARD_TICKS(4)) u_dut_g4 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_width(req_width),
        .scram_ext(scram_ext), .scram_clear(scram_clear),
        .grant(grant_o[0]), .pulse_out(pulse_o[0]), .pulse_owner(owner_o[0]),
        .busy(busy_o[0]), .safety_scram(scram_o[0]), .scram_src(src_o[0])
    );

    braid_pulse_scheduler #(.N_REQ(N), .MIN_TICKS(MIN_W), .GUARD_TICKS(0)) u_dut_g0 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_width(req_width),
        .scram_ext(scram_ext), .scram_clear(scram_clear),
        .grant(grant_o[1]), .pulse_out(pulse_o[1]), .pulse_owner(owner_o[1]),
        .busy(busy_o[1]), .safety_scram(scram_o[1]), .scram_src(src_o[1])
    );

    // Model: each scheduler is described by the edge of its last grant and the
    // edges at which its pulse, busy window and arbitration hold-off end.
    longint     t;
    longint     m_k    [2];
    longint     m_pend [2];
    longint     m_bend [2];
    longint     m_arb  [2];
    int         m_owner[2];
    int         m_ptr  [2];
    bit         m_scram[2];
    logic [3:0] m_src  [2];

    int n_vec = 0;
    int n_err = 0;
    int ext_hold = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        int  w = 0;
        bit  f = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!f && r[(p + off) % N]) begin
                f = 1'b1;
                w = (p + off) % N;
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_k[j] = -1000; m_pend[j] = -1000; m_bend[j] = -1000; m_arb[j] = 0;
            m_owner[j] = 0; m_ptr[j] = 0; m_scram[j] = 1'b0; m_src[j] = 4'd0;
        end
    endtask

    task automatic model_edge();
        t++;
        for (int j = 0; j < 2; j++) begin
            if (!m_scram[j] && scram_ext) begin
                m_scram[j] = 1'b1;
                m_src[j]   = {1'b1, 3'(m_owner[j])};
                if (m_pend[j] > t) m_pend[j] = t;
                if (m_bend[j] > t) m_bend[j] = t;
            end else if (m_scram[j]) begin
                if (scram_clear && !scram_ext) begin
                    m_scram[j] = 1'b0;
                    m_ptr[j]   = 0;
                    m_arb[j]   = t + 1;
                end
            end else if (req != '0 && t >= m_arb[j]) begin
                int w  = pick(req, m_ptr[j]);
                int wd = int'(req_width[8*w +: 8]);
                if (wd < MIN_W) begin
                    m_scram[j] = 1'b1;
                    m_src[j]   = {1'b0, 3'(w)};
                end else begin
                    m_k[j]     = t;
                    m_owner[j] = w;
                    m_pend[j]  = t + wd;
                    m_bend[j]  = t + wd + gt[j];
                    m_arb[j]   = t + wd + ((gt[j] == 0) ? 1 : gt[j]);
`ifdef ALETHEIA_SCHED_RR_EN
                    m_ptr[j]   = (w + 1) % N;
`endif
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int j = 0; j < 2; j++) begin
            logic [N-1:0] eg;
            eg = (m_k[j] == t) ? N'(1 << m_owner[j]) : '0;
            check_value($sformatf("grant_g%0d", gt[j]), 32'(grant_o[j]), 32'(eg));
            check_value($sformatf("pulse_g%0d", gt[j]), 32'(pulse_o[j]),
                        32'(t >= m_k[j] && t < m_pend[j]));
            check_value($sformatf("owner_g%0d", gt[j]), 32'(owner_o[j]), 32'(m_owner[j]));
            check_value($sformatf("busy_g%0d", gt[j]), 32'(busy_o[j]),
                        32'(t >= m_k[j] && t < m_bend[j]));
            check_value($sformatf("scram_g%0d", gt[j]), 32'(scram_o[j]), 32'(m_scram[j]));
            check_value($sformatf("src_g%0d", gt[j]), 32'(src_o[j]), 32'(m_src[j]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        t = 0;
        rst_n = 1'b1;
        req = '0;
        req_width = {N{8'd10}};
        scram_ext = 1'b0;
        scram_clear = 1'b0;
        @(negedge clk);
        apply_reset();
        repeat (3) step();

        // single pulse on requester 1
        req_width[15:8] = 8'd12;
        req = 4'b0010;
        step();
        check_value("single_grant", 32'(grant_o[0]), 32'h2);
        req = '0;
        repeat (20) step();

        // width violation on requester 2, then clear
        req_width[23:16] = 8'd9;
        req = 4'b0100;
        step();
        check_value("viol_src", 32'(src_o[0]), 32'h2);
        check_value("viol_noPulse", 32'(pulse_o[0]), 32'h0);
        req = '0;
        repeat (3) step();
        scram_clear = 1'b1;
        step();
        scram_clear = 1'b0;
        check_value("viol_cleared", 32'(scram_o[0]), 32'h0);
        repeat (3) step();

        // all requesters held at width 10
        req_width = {N{8'd10}};
        req = 4'hF;
        repeat (75) step();
        req = '0;
        repeat (20) step();

        // external fault 5 cycles into a 20-tick pulse from requester 3
        req_width[31:24] = 8'd20;
        req = 4'b1000;
        step();
        req = '0;
        repeat (4) step();
        scram_ext = 1'b1;
        step();
        check_value("abort_pulse", 32'(pulse_o[0]), 32'h0);
        check_value("abort_src", 32'(src_o[0]), 32'hB);
        scram_clear = 1'b1;
        step();
        check_value("clear_ignored", 32'(scram_o[0]), 32'h1);
        scram_clear = 1'b0;
        scram_ext = 1'b0;
        step();
        scram_clear = 1'b1;
        step();
        scram_clear = 1'b0;
        check_value("abort_cleared", 32'(scram_o[0]), 32'h0);
        repeat (3) step();

        // reset in the middle of a pulse, request pending afterwards
        req_width[7:0] = 8'd30;
        req = 4'b0001;
        step();
        req = '0;
        repeat (3) step();
        apply_reset();
        req = 4'b0001;
        step();
        check_value("post_reset_grant", 32'(grant_o[1]), 32'h1);
        req = '0;
        repeat (35) step();

        // maximum width held on requester 0
        req_width[7:0] = 8'd255;
        req = 4'b0001;
        repeat (600) step();
        req = '0;
        repeat (300) step();

        // randomized traffic
        req_width = {N{8'd12}};
        repeat (2500) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 4) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 5) == 0)
                    req_width[8*i +: 8] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 9))
                                                                       : 8'($urandom_range(10, 24));
            end
            if (ext_hold > 0) begin
                ext_hold--;
                scram_ext = 1'b1;
            end else begin
                scram_ext = 1'b0;
                if ($urandom_range(0, 199) == 0) ext_hold = $urandom_range(1, 4);
            end
            scram_clear = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
